// File: rtl/udcnt_pkg.sv
// rtl/udcnt_pkg.sv - shared constants and load-clamp helper for udcnt_param
package udcnt_pkg;

  localparam int  MAX_W    = 16;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values are carried one bit wider than the largest counter so MODULUS == 2**16 fits.
  function automatic logic [MAX_W:0] clamp_load(input logic [MAX_W:0] value,
                                                input logic [MAX_W:0] modulus);
    return (value < modulus) ? value : (modulus - 1'b1);
  endfunction

endpackage

// File: rtl/udcnt_bound.sv
// rtl/udcnt_bound.sv - boundary detector: q at MODULUS-1 (at_max) or at 0 (at_min)
module udcnt_bound
  import udcnt_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0] MAX_V = (WIDTH + 1)'(MODULUS - 1);

  assign at_max = ({1'b0, q} == MAX_V);
  assign at_min = (q == '0);

endmodule

// File: rtl/udcnt_param.sv
// rtl/udcnt_param.sv - parametrised up/down counter with load, tc and wrap pulse
// UDCNT_SAT_EN selects saturating mode; default build wraps around.
module udcnt_param
  import udcnt_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 2 ** WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ld_err
);

  generate
    if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_width
      $error("udcnt_param: WIDTH out of range 1..16");
    end
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("udcnt_param: MODULUS out of range 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
      $error("udcnt_param: RESET_VAL must be below MODULUS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [MAX_W:0]   MOD_W = (MAX_W + 1)'(MODULUS);

  logic             at_max;
  logic             at_min;
  logic [WIDTH:0]   q_up;
  logic [WIDTH:0]   q_dn;
  logic [MAX_W:0]   din_w;
  logic             din_oor;

  udcnt_bound #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_bound (
    .q      (q),
    .at_max (at_max),
    .at_min (at_min)
  );

  // Step arithmetic one bit wide so q+1 at 2**WIDTH-1 never aliases to 0 early.
  assign q_up    = {1'b0, q} + 1'b1;
  assign q_dn    = {1'b0, q} - 1'b1;
  assign din_w   = (MAX_W + 1)'(din);
  assign din_oor = (din_w >= MOD_W);

  assign tc = en & ((ud & at_max) | (~ud & at_min));

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= RST_V;
      wrap   <= 1'b0;
      ld_err <= 1'b0;
    end else if (load) begin
      q      <= WIDTH'(clamp_load(din_w, MOD_W));
      wrap   <= 1'b0;
      ld_err <= din_oor;
    end else if (en) begin
      ld_err <= 1'b0;
      if (ud == DIR_UP) begin
        if (at_max) begin
`ifdef UDCNT_SAT_EN
          q <= MAX_Q;
`else
          q <= '0;
`endif
          wrap <= 1'b1;
        end else begin
          q    <= q_up[WIDTH-1:0];
          wrap <= 1'b0;
        end
      end else begin
        if (at_min) begin
`ifdef UDCNT_SAT_EN
          q <= '0;
`else
          q <= MAX_Q;
`endif
          wrap <= 1'b1;
        end else begin
          q    <= q_dn[WIDTH-1:0];
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap   <= 1'b0;
      ld_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udcnt_param.sv
// tb/tb_udcnt_param.sv - vector bench: u0 WIDTH=3 MODULUS=8, u1 WIDTH=3 MODULUS=6 RESET_VAL=2
module tb_udcnt_param;

`ifdef UDCNT_SAT_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  typedef struct {
    int       sel;
    logic     rst, en, ud, load;
    logic [2:0] din;
    logic     tc;
    logic [2:0] q;
    logic     wrap, err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, ud0, load0, tc0, wrap0, err0;
  logic [2:0] din0, q0;
  logic       rst1, en1, ud1, load1, tc1, wrap1, err1;
  logic [2:0] din1, q1;

  udcnt_param u0 (
    .clk(clk), .rst(rst0), .en(en0), .ud(ud0), .load(load0), .din(din0),
    .q(q0), .tc(tc0), .wrap(wrap0), .ld_err(err0)
  );

  udcnt_param #(.WIDTH(3), .MODULUS(6), .RESET_VAL(2)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .ud(ud1), .load(load1), .din(din1),
    .q(q1), .tc(tc1), .wrap(wrap1), .ld_err(err1)
  );

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic add(input int sel, input int rst, input int en, input int ud,
                     input int load, input int din, input int tc, input int q,
                     input int wrap, input int err);
    vec_t v;
    v.sel = sel; v.rst = rst[0]; v.en = en[0]; v.ud = ud[0]; v.load = load[0];
    v.din = 3'(din); v.tc = tc[0]; v.q = 3'(q); v.wrap = wrap[0]; v.err = err[0];
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] act,
                       input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst0 = 0; en0 = 0; ud0 = 0; load0 = 0; din0 = '0;
    rst1 = 0; en1 = 0; ud1 = 0; load1 = 0; din1 = '0;
    if (v.sel == 0) begin
      rst0 = v.rst; en0 = v.en; ud0 = v.ud; load0 = v.load; din0 = v.din;
    end else begin
      rst1 = v.rst; en1 = v.en; ud1 = v.ud; load1 = v.load; din1 = v.din;
    end
  endtask

  initial begin
    // u0: count up through the wrap, direction change, load-with-enable, reset over load
    for (int i = 1; i <= 7; i++) add(0, 0,1,1,0,0, 0, i, 0,0);
    add(0, 0,1,1,0,0, 1,   SAT ? 7 : 0, 1,   0);
    add(0, 0,1,1,0,0, SAT, SAT ? 7 : 1, SAT, 0);
    add(0, 0,1,1,0,0, SAT, SAT ? 7 : 2, SAT, 0);
    add(0, 0,1,0,0,0, 0,   SAT ? 6 : 1, 0,   0);
    add(0, 0,1,1,1,3, 0, 3, 0,0);
    add(0, 0,1,1,0,0, 0, 4, 0,0);
    add(0, 0,0,0,0,0, 0, 4, 0,0);
    add(0, 0,0,0,1,7, 0, 7, 0,0);
    add(0, 0,1,1,0,0, 1, SAT ? 7 : 0, 1,0);
    add(0, 0,0,0,0,0, 0, SAT ? 7 : 0, 0,0);
    add(0, 0,0,0,1,0, 0, 0, 0,0);
    add(0, 0,1,0,0,0, 1,   SAT ? 0 : 7, 1,   0);
    add(0, 0,1,0,0,0, SAT, SAT ? 0 : 6, SAT, 0);
    add(0, 1,1,0,1,5, SAT, 0, 0,0);
    add(0, 0,1,0,1,2, 1,   2, 0,0);
    // u1: modulus 6, reset value 2, clamped loads, reset together with load
    add(1, 1,0,0,0,0, 0, 2, 0,0);
    add(1, 0,1,0,0,0, 0, 1, 0,0);
    add(1, 0,1,0,0,0, 0, 0, 0,0);
    add(1, 0,1,0,0,0, 1,   SAT ? 0 : 5, 1,   0);
    add(1, 0,1,0,0,0, SAT, SAT ? 0 : 4, SAT, 0);
    add(1, 0,0,0,1,7, 0, 5, 0,1);
    add(1, 0,0,0,0,0, 0, 5, 0,0);
    add(1, 0,0,0,1,6, 0, 5, 0,1);
    add(1, 0,0,0,1,5, 0, 5, 0,0);
    add(1, 0,1,1,0,0, 1, SAT ? 5 : 0, 1,0);
    add(1, 0,1,0,1,3, SAT ? 0 : 1, 3, 0,0);
    add(1, 0,1,1,0,0, 0, 4, 0,0);
    add(1, 1,1,1,1,5, 0, 2, 0,0);
    add(1, 0,1,1,0,0, 0, 3, 0,0);
    add(1, 0,1,1,0,0, 0, 4, 0,0);
    add(1, 0,1,1,0,0, 0, 5, 0,0);
    add(1, 0,1,0,0,0, 0, 4, 0,0);
    add(1, 0,0,0,1,7, 0, 5, 0,1);
    add(1, 1,0,0,0,0, 0, 2, 0,0);

    // Reset both counters for two cycles with u0 enabled counting up
    rst0 = 1; en0 = 1; ud0 = 1; load0 = 0; din0 = '0;
    rst1 = 1; en1 = 0; ud1 = 0; load1 = 0; din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q0",    -1, q0,          3'd0);
    check("reset_wrap0", -1, {2'b0, wrap0}, 3'd0);
    check("reset_err0",  -1, {2'b0, err0},  3'd0);
    check("reset_tc0",   -1, {2'b0, tc0},   3'd0);
    check("reset_q1",    -1, q1,          3'd2);
    check("reset_wrap1", -1, {2'b0, wrap1}, 3'd0);
    check("reset_err1",  -1, {2'b0, err1},  3'd0);
    // tc follows ud combinationally while reset is held
    ud0 = 0;
    en1 = 1;
    #1;
    check("reset_tc0_down", -1, {2'b0, tc0}, 3'd1);
    check("reset_tc1_down", -1, {2'b0, tc1}, 3'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check(vecs[i].sel == 0 ? "tc0" : "tc1", i,
            {2'b0, (vecs[i].sel == 0) ? tc0 : tc1}, {2'b0, vecs[i].tc});
      @(posedge clk);
      #1;
      if (vecs[i].sel == 0) begin
        check("q0",    i, q0,            vecs[i].q);
        check("wrap0", i, {2'b0, wrap0}, {2'b0, vecs[i].wrap});
        check("err0",  i, {2'b0, err0},  {2'b0, vecs[i].err});
      end else begin
        check("q1",    i, q1,            vecs[i].q);
        check("wrap1", i, {2'b0, wrap1}, {2'b0, vecs[i].wrap});
        check("err1",  i, {2'b0, err1},  {2'b0, vecs[i].err});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
